wm_round_ctrl: RTL and testbench

WM_ROUND_CTRL -- requirements
Module: wm_round_ctrl

---
 rtl/wm_pkg.sv | 23 ++
 rtl/wm_round_timer.sv | 45 ++++
 rtl/wm_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_wm_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the whack-a-mole round controller.
//   - default parameter values for the controller
//   - FSM state enumeration
//   - saturating 8-bit increment used for the score
package wm_pkg;

  localparam int WM_NUM_BTN = 4;
  localparam int WM_TIMEOUT = 500;
  localparam int WM_ROUNDS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } wm_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wm_round_timer.sv
// Per-round cycle counter.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, clears the count
//   clear  : force count to 0 (held while the controller is arming a round)
//   en     : advance count by one per cycle
//   expire : count has reached TIMEOUT-1 (last allowed cycle of the round)
// The count stops at TIMEOUT-1 so it can never wrap, even if enable stays
// high for longer than a round.
module wm_round_timer
  import wm_pkg::*;
#(
  parameter int TIMEOUT = WM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/wm_round_ctrl.sv
// Whack-a-mole game round controller.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   start     : level, begins a new game when idle or finished
//   rn        : random target index, folded modulo NUM_BTN when latched
//   btn       : debounced button levels, bit i = button i
//   target    : one-hot lit mole while waiting for a press, else 0
//   hit/miss  : one-cycle round outcome pulses
//   score     : hits in the current game, saturating at 255
//   round_idx : 0-based index of the current round
//   busy      : game in progress
//   done      : game finished, held until next start or reset
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARM    | waiting for all buttons released, then latches the target
// WAIT   | mole lit, timer running, watching for a press or timeout
// RESULT | one cycle, hit/miss pulse visible, advance or finish
// DONE   | game over, done held, waiting for start
module wm_round_ctrl
  import wm_pkg::*;
#(
  parameter  int NUM_BTN = WM_NUM_BTN,
  parameter  int TIMEOUT = WM_TIMEOUT,
  parameter  int ROUNDS  = WM_ROUNDS,
  localparam int IDX_W   = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   rn,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] target,
  output logic               hit,
  output logic               miss,
  output logic [7:0]         score,
  output logic [7:0]         round_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

  wm_state_e          state_q, state_d;
  logic [IDX_W-1:0]   tgt_q, tgt_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         round_q, round_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic [NUM_BTN-1:0] tgt_mask;
  logic               any_press;
  logic               right_press;
  logic               expire;

  wm_round_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_ARM),
    .en    (state_q == ST_WAIT),
    .expire(expire)
  );

  assign tgt_mask    = NUM_BTN'(1) << tgt_q;
  assign any_press   = |btn;
  // Exact match only: the target together with any other button is a wrong press.
  assign right_press = (btn == tgt_mask);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    score_d = score_q;
    round_d = round_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ARM;
          score_d = '0;
          round_d = '0;
        end
      end

      ST_ARM: begin
        if (!any_press) begin
          state_d = ST_WAIT;
          // Out-of-range generator values wrap back onto a real button.
          tgt_d   = IDX_W'(32'(rn) % NUM_BTN);
        end
      end

      ST_WAIT: begin
        // A press on the final cycle still counts as a press, not a timeout.
        if (any_press) begin
          state_d = ST_RESULT;
          if (right_press) begin
            hit_d   = 1'b1;
            score_d = sat_inc8(score_q);
          end else begin
            miss_d  = 1'b1;
          end
        end else if (expire) begin
          state_d = ST_RESULT;
          miss_d  = 1'b1;
        end
      end

      ST_RESULT: begin
        if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ARM;
          round_d = round_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      score_q <= '0;
      round_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      score_q <= score_d;
      round_q <= round_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign target    = (state_q == ST_WAIT) ? tgt_mask : '0;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign round_idx = round_q;
  assign busy      = (state_q == ST_ARM) || (state_q == ST_WAIT) || (state_q == ST_RESULT);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_wm_round_ctrl.sv
// Bench for wm_round_ctrl: directed and random games checked against a
// round-level model (target = rn mod NB, outcome from press pattern/time).
module tb_wm_round_ctrl;

  localparam int NB = 5;
  localparam int TO = 500;
  localparam int RN = 3;

  typedef struct {
    int rn;
    int press;
    int pat;
    int hold;
  } rnd_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [2:0]    rn;
  logic [NB-1:0] btn;
  logic [NB-1:0] target;
  logic          hit;
  logic          miss;
  logic [7:0]    score;
  logic [7:0]    round_idx;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score;

  wm_round_ctrl #(.NUM_BTN(NB), .TIMEOUT(TO), .ROUNDS(RN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rn       (rn),
    .btn      (btn),
    .target   (target),
    .hit      (hit),
    .miss     (miss),
    .score    (score),
    .round_idx(round_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [NB-1:0] mask_of(input int rn_v);
    logic [NB-1:0] m;
    m = '0;
    m[rn_v % NB] = 1'b1;
    return m;
  endfunction

  // Caller leaves the DUT in ARM or RESULT; exp_lat is the number of edges
  // until the mole should light after btn is released.
  task automatic play_round(input int r, input rnd_t rd, input int exp_lat);
    logic [NB-1:0] mask;
    int guard;
    int last;
    bit early;
    bit lit_ok;
    bit exp_h;
    mask  = mask_of(rd.rn);
    rn    = 3'(rd.rn);
    btn   = '0;
    guard = 0;
    while (target == '0 && guard < 10) begin
      tick();
      guard++;
    end
    check_eq("arm_latency", guard, exp_lat);
    if (target == '0) return;
    check_eq("target", target, mask);
    check_eq("round_idx_wait", round_idx, r);
    rn    = 3'($urandom);
    start = 1'($urandom_range(0, 1));
    last  = (rd.press < 0) ? TO - 1 : rd.press;
    early = 0;
    lit_ok = 1;
    for (int c = 0; c < last; c++) begin
      tick();
      if (hit || miss) early = 1;
      if (target != mask) lit_ok = 0;
    end
    start = 1'b0;
    if (rd.press >= 0) btn = NB'(rd.pat);
    tick();
    exp_h = (rd.press >= 0) && (NB'(rd.pat) == mask);
    if (exp_h) exp_score = sat8(exp_score + 1);
    check_eq("early_pulse", early, 0);
    check_eq("target_lit", lit_ok, 1);
    check_eq("hit", hit, exp_h);
    check_eq("miss", miss, !exp_h);
    check_eq("score", score, exp_score);
    check_eq("target_result", target, 0);
    for (int h = 0; h < rd.hold; h++) begin
      tick();
      check_eq("arm_hold_target", target, 0);
      check_eq("arm_hold_pulse", hit | miss, 0);
      check_eq("arm_hold_busy", busy, 1);
      check_eq("arm_hold_round", round_idx, r + 1);
    end
    btn = '0;
  endtask

  task automatic play_game(input rnd_t g[RN]);
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_score", score, 0);
    check_eq("start_round", round_idx, 0);
    lat = 1;
    for (int r = 0; r < RN; r++) begin
      play_round(r, g[r], lat);
      lat = (g[r].hold > 0) ? 1 : 2;
    end
    tick();
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_round", round_idx, RN - 1);
    check_eq("end_score", score, exp_score);
    tick();
    check_eq("done_level", done, 1);
    check_eq("done_pulse", hit | miss, 0);
  endtask

  function automatic rnd_t rand_round(input bit is_last);
    rnd_t rd;
    int sel;
    rd.rn = int'($urandom_range(0, 7));
    sel = int'($urandom_range(0, 7));
    if (sel < 2) rd.press = -1;
    else if (sel == 2) rd.press = TO - 1;
    else if (sel == 3) rd.press = 0;
    else rd.press = int'($urandom_range(1, 60));
    if ($urandom_range(0, 1) == 1) rd.pat = int'(mask_of(rd.rn));
    else rd.pat = int'($urandom_range(1, (1 << NB) - 1));
    rd.hold = (rd.press >= 0 && !is_last) ? int'($urandom_range(0, 3)) : 0;
    return rd;
  endfunction

  rnd_t g[RN];
  logic [NB-1:0] m;

  initial begin
    reset = 1'b1;
    start = 1'b1;
    rn    = 3'd5;
    btn   = 5'b10101;
    tick();
    tick();
    check_eq("rst_target", target, 0);
    check_eq("rst_hit", hit, 0);
    check_eq("rst_miss", miss, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_round", round_idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    start = 1'b0;
    btn   = '0;
    reset = 1'b0;
    tick();
    check_eq("idle_busy", busy, 0);

    // hit at cycle 10, wrong multi-press with hold, plain timeout
    g[0] = '{rn: 2, press: 10, pat: 5'b00100, hold: 0};
    g[1] = '{rn: 1, press: 5, pat: 5'b00011, hold: 2};
    g[2] = '{rn: 3, press: -1, pat: 0, hold: 0};
    play_game(g);

    // folded rn, correct press on the last cycle, press at cycle 0, target+extra
    g[0] = '{rn: 6, press: TO - 1, pat: 5'b00010, hold: 3};
    g[1] = '{rn: 4, press: 0, pat: 5'b10000, hold: 1};
    g[2] = '{rn: 0, press: 20, pat: 5'b00011, hold: 0};
    play_game(g);

    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < RN; r++) g[r] = rand_round(r == RN - 1);
      play_game(g);
    end

    // reset in the middle of round 1 WAIT after a scoring round 0
    g[0] = '{rn: 2, press: 3, pat: 5'b00100, hold: 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    play_round(0, g[0], 1);
    rn = 3'd1;
    for (int c = 0; c < 10 && target == '0; c++) tick();
    check_eq("r1_target", target, 5'b00010);
    for (int c = 0; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_target", target, 0);
    check_eq("mid_rst_pulse", hit | miss, 0);
    check_eq("mid_rst_score", score, 0);
    check_eq("mid_rst_round", round_idx, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    tick();
    check_eq("post_rst_pulse", hit | miss, 0);
    check_eq("post_rst_busy", busy, 0);

    // reset on the edge that would have entered RESULT with a hit
    start = 1'b1;
    rn    = 3'd4;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10 && target == '0; c++) tick();
    m = mask_of(4);
    check_eq("r0_target", target, m);
    btn   = m;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    btn   = '0;
    check_eq("res_rst_hit", hit, 0);
    check_eq("res_rst_score", score, 0);
    check_eq("res_rst_busy", busy, 0);
    tick();
    check_eq("res_rst_after", hit | miss, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
